// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full adder stepped over WIDTH cycles, LSB first,
// with a start/done handshake. Subtraction is a + ~b + 1, so co=1 means "no borrow".

module add1 (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             sum_bit;
  logic             carry_bit;

  add1 u_add1 (
    .a  (op_a[0]),
    .b  (op_b[0]),
    .ci (cy),
    .s  (sum_bit),
    .co (carry_bit)
  );

  // The new sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  always_comb begin
    acc_next            = acc >> 1;
    acc_next[WIDTH-1]   = sum_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      co    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            cy    <= sub | ci;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          op_a <= op_a >> 1;
          op_b <= op_b >> 1;
          acc  <= acc_next;
          cy   <= carry_bit;
          cnt  <= cnt + CW'(1);
          // Results publish only here, so s/co hold the previous answer throughout RUN.
          if (cnt == LAST_CNT) begin
            s     <= acc_next;
            co    <= carry_bit;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed and random operations on WIDTH=8,
// exhaustive WIDTH=4, and WIDTH=1 latency, all against an arithmetic reference.

module tb_serial_add_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, sub8, ci8, busy8, done8, co8;
  logic [7:0] a8, b8, s8;
  logic       start4, sub4, ci4, busy4, done4, co4;
  logic [3:0] a4, b4, s4;
  logic       start1, sub1, ci1, busy1, done1, co1;
  logic [0:0] a1, b1, s1;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;
  int last_expected = 0;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .ci(ci8),
    .busy(busy8), .done(done8), .s(s8), .co(co8)
  );
  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4), .ci(ci4),
    .busy(busy4), .done(done4), .s(s4), .co(co4)
  );
  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1), .ci(ci1),
    .busy(busy1), .done(done1), .s(s1), .co(co1)
  );

  // Reference: {co,s} = a + b + ci, or a + ~b + 1 when subtracting, over `width` bits.
  function automatic int ref_result(input int width, input int a, input int b,
                                    input bit ci, input bit sub);
    int mask;
    int bb;
    mask = (1 << width) - 1;
    bb   = sub ? (~b & mask) : (b & mask);
    return (a & mask) + bb + (sub ? 1 : int'(ci));
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One full WIDTH=8 operation with timing checks; operands are scrambled after accept.
  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b,
                                input logic ci, input logic sub);
    int exp;
    int waited;
    int busy_cycles;
    exp = ref_result(8, int'(a), int'(b), ci, sub);
    @(negedge clk);
    a8 = a; b8 = b; ci8 = ci; sub8 = sub; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); sub8 = 1'($urandom);
    waited = 1;
    busy_cycles = 0;
    while (done8 !== 1'b1 && waited < 30) begin
      if (busy8 === 1'b1) busy_cycles++;
      @(negedge clk);
      waited++;
    end
    check_output("w8_latency", 32'(waited), 32'd9);
    check_output("w8_busy_cycles", 32'(busy_cycles), 32'd8);
    check_output("w8_result", {23'd0, co8, s8}, 32'(exp));
    check_output("w8_busy_in_done", {31'd0, busy8}, 32'd0);
    @(negedge clk);
    check_output("w8_done_pulse", {31'd0, done8}, 32'd0);
    last_expected = exp;
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                      input logic sub);
    int waited;
    @(negedge clk);
    a4 = a; b4 = b; ci4 = ci; sub4 = sub; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    waited = 1;
    while (done4 !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_output("w4_result", {waited == 5 ? 27'd0 : 27'h7ffffff, co4, s4},
                 32'(ref_result(4, int'(a), int'(b), ci, sub)));
  endtask

  task automatic run1(input logic a, input logic b, input logic ci, input logic sub);
    int waited;
    @(negedge clk);
    a1 = a; b1 = b; ci1 = ci; sub1 = sub; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    waited = 1;
    while (done1 !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check_output("w1_latency", 32'(waited), 32'd2);
    check_output("w1_result", {30'd0, co1, s1},
                 32'(ref_result(1, int'(a), int'(b), ci, sub)));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp;
    int done_count;
    int done_k;
    int stray_done;

    rst = 1'b1;
    start8 = 0; sub8 = 0; ci8 = 0; a8 = '0; b8 = '0;
    start4 = 0; sub4 = 0; ci4 = 0; a4 = '0; b4 = '0;
    start1 = 0; sub1 = 0; ci1 = 0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    check_output("reset_busy", {31'd0, busy8}, 32'd0);
    check_output("reset_done", {31'd0, done8}, 32'd0);
    check_output("reset_s", {24'd0, s8}, 32'd0);
    check_output("reset_co", {31'd0, co8}, 32'd0);
    rst = 1'b0;

    apply_stimulus(8'h5A, 8'h3C, 1'b0, 1'b0);
    check_output("t1_const", {23'd0, co8, s8}, 32'h096);
    apply_stimulus(8'hFF, 8'h01, 1'b0, 1'b0);
    check_output("t2a_const", {23'd0, co8, s8}, 32'h100);
    apply_stimulus(8'hFF, 8'h00, 1'b1, 1'b0);
    check_output("t2b_const", {23'd0, co8, s8}, 32'h100);
    apply_stimulus(8'h10, 8'h01, 1'b0, 1'b1);
    check_output("t3a_const", {23'd0, co8, s8}, 32'h10F);
    apply_stimulus(8'h00, 8'h01, 1'b0, 1'b1);
    check_output("t3b_const", {23'd0, co8, s8}, 32'h0FF);

    // Extra starts in RUN (cycle 3) and DONE (cycle 9) must not produce a second result.
    exp = ref_result(8, 'h12, 'h34, 1'b1, 1'b0);
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; ci8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
    done_count = 0;
    done_k = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start8 = (k == 3 || k == 9);
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); sub8 = 1'($urandom);
      if (done8 === 1'b1) begin
        done_count++;
        done_k = k;
        check_output("t4_result", {23'd0, co8, s8}, 32'(exp));
      end else if (k < 9) begin
        check_output("t4_hold", {23'd0, co8, s8}, 32'(last_expected));
      end
    end
    start8 = 1'b0;
    check_output("t4_done_count", 32'(done_count), 32'd1);
    check_output("t4_done_cycle", 32'(done_k), 32'd9);
    check_output("t4_idle_busy", {31'd0, busy8}, 32'd0);
    last_expected = exp;

    // Reset in the middle of RUN aborts without a done pulse.
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'h7E; ci8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("t5_busy", {31'd0, busy8}, 32'd0);
    check_output("t5_done", {31'd0, done8}, 32'd0);
    check_output("t5_result", {23'd0, co8, s8}, 32'd0);
    stray_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 !== 1'b0) stray_done++;
    end
    check_output("t5_no_done", 32'(stray_done), 32'd0);
    apply_stimulus(8'hC3, 8'h7E, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++)
      apply_stimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          run4(4'(a), 4'(b), 1'(c), 1'b0);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run4(4'(a), 4'(b), 1'($urandom), 1'b1);

    for (int v = 0; v < 8; v++)
      run1(v[2], v[1], v[0], 1'b0);
    for (int v = 0; v < 4; v++)
      run1(v[1], v[0], 1'b0, 1'b1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
